uart_ctrl: RTL and testbench
============================

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter STOP_TICKS, default 16, stop-bit duration in oversample ticks (16/24/32).
REQ-003 SHALL have parameter FIFO_W, default 2, FIFO address bits; each FIFO depth 2**FIFO_W.
REQ-004 SHALL have parameter DIV_W, default 16, width of runtime baud divisor.
REQ-005 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even (used only with UART_PARITY_EN).
REQ-006 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: divisor  in  DIV_W  clk cycles per 16x tick; rd  in  1  pop RX FIFO; wr  in  1  push TX FIFO; w_data  in  DATA_BITS  TX data.
REQ-008 SHALL have ports: r_in  in  1  serial RX line; t_out  out  1  serial TX line; r_data  out  DATA_BITS  RX FIFO head.
REQ-009 SHALL have ports: r_empty, r_full, t_full, tx_busy  out  1  status; err_frame, err_parity, err_overrun  out  1  sticky errors; err_clr  in  1  clear errors.

Function
REQ-010 Tick counter SHALL count 0..divisor-1 and pulse tick one cycle at divisor-1; divisor 0 or 1 SHALL tick every cycle; divisor change SHALL take effect at next wrap.
REQ-011 RX SHALL synchronise r_in through two flops before use.
REQ-012 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on synchronised r_in low.
REQ-013 START SHALL wait 7 ticks, resample; low -> DATA, high -> IDLE (glitch rejected, nothing pushed).
REQ-014 DATA SHALL sample every 16 ticks, LSB first, DATA_BITS samples; then PARITY (if enabled) else STOP.
REQ-015 STOP SHALL sample at 16 ticks; low sample SHALL set err_frame and still push the word; FSM returns IDLE after STOP_TICKS ticks.
REQ-016 Completed word SHALL be pushed to RX FIFO in the cycle STOP ends; if RX FIFO full, word SHALL be dropped and err_overrun set.
REQ-017 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START when TX FIFO non-empty, latching FIFO head.
REQ-018 t_out SHALL be 1 in IDLE/STOP, 0 in START, data bit LSB first in DATA; each bit 16 ticks, stop STOP_TICKS ticks.
REQ-019 TX FIFO SHALL be popped once per frame at STOP end; next frame SHALL start without idle gap if FIFO non-empty.
REQ-020 tx_busy SHALL be 1 whenever TX FSM not IDLE.
REQ-021 FIFOs SHALL be first-word-fall-through; r_data valid while r_empty=0; rd when empty and wr when full SHALL be ignored.
REQ-022 Simultaneous push and pop on a non-empty, non-full FIFO SHALL keep occupancy; on full FIFO simultaneous rd-then-wr SHALL both succeed; pointers wrap modulo 2**FIFO_W.
REQ-023 Errors SHALL be sticky until err_clr; err_clr coincident with a new error event SHALL leave the error set.

Reset
REQ-024 reset low at a clk edge SHALL force both FSMs IDLE, FIFOs empty, tick counter 0, synchronisers to 1.
REQ-025 Reset values: t_out=1, r_empty=1, r_full=0, t_full=0, tx_busy=0, all err_*=0, r_data=0.
REQ-026 Reset mid-frame SHALL abort the frame; no partial word SHALL be pushed.

Configuration
REQ-027 With macro UART_PARITY_EN defined, one parity bit (even or odd per PARITY_ODD) SHALL be sent after data, and RX mismatch SHALL set err_parity while still pushing the word.
REQ-028 Without UART_PARITY_EN, PARITY states SHALL not exist and err_parity SHALL be tied 0.

Structure
REQ-029 Package uart_pkg SHALL hold the RX/TX state enum, OVERSAMPLE=16, and START_MID=7 constants.
REQ-030 One sub-module uart_fifo (parametrised width/depth, FWFT) SHALL be instantiated twice; baud, RX and TX logic stay inline.

Verification
REQ-031 divisor=4, wr 0xA5 -> t_out start bit low for 64 cycles, then bits 1,0,1,0,0,1,0,1 at 64 cycles each, stop high.
REQ-032 Loop t_out to r_in, write 0x00,0xFF,0x3C -> same three words read back in order, no errors.
REQ-033 r_in low pulse of 3 ticks -> no push, r_empty stays 1.
REQ-034 Frame 0x55 with stop bit driven low -> err_frame=1, 0x55 in RX FIFO; err_clr -> err_frame=0.
REQ-035 FIFO_W=2, receive 5 frames without rd -> r_full=1, first 4 words retained, err_overrun=1.
REQ-036 UART_PARITY_EN, PARITY_ODD=0, receive 0x07 with parity bit 0 -> err_parity=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for uart_ctrl: frame state encoding and oversampling constants.
// The PARITY state is present only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;
`endif

    // Callers zero-extend narrower words, which does not change the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO of 2**AW entries; r_data reads 0 while empty.
// A pop and a push in the same cycle on a full FIFO both succeed.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic [WIDTH-1:0] next_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    nxt_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign nxt_ptr = rd_ptr + AW'(1);

    assign r_data    = empty ? '0 : mem[rd_ptr];
    // Second entry, letting a consumer chain frames without waiting for the pop to settle.
    assign next_data = mem[nxt_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= nxt_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= w_data;
    end

endmodule

// File: rtl/uart_ctrl.sv
// UART with runtime baud divisor, 16x oversampled receiver, FWFT RX/TX FIFOs and sticky errors.
// Define UART_PARITY_EN to add one parity bit per frame (odd when PARITY_ODD=1).
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16,
    parameter int FIFO_W     = 2,
    parameter int DIV_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] w_data,
    input  logic                 r_in,
    output logic                 t_out,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 r_empty,
    output logic                 r_full,
    output logic                 t_full,
    output logic                 tx_busy,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun,
    input  logic                 err_clr
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;

    // The divisor is captured at each wrap so a change never shortens a running period.
    assign tick = (div_q <= DIV_W'(1)) || (tick_cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            div_q    <= divisor;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    uart_state_t          rx_state;
    logic [1:0]           rx_sync;
    logic                 rx_s;
    logic [5:0]           rx_tcnt;
    logic [3:0]           rx_bits;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_stop_bad;
    logic                 rx_bit_end;
    logic                 rx_stop_end;
    logic                 rx_stop_low;
    logic                 frame_evt;
    logic                 overrun_evt;
    logic [DATA_BITS-1:0] rx_next_unused;
    logic [FIFO_W:0]      rx_count_unused;

    assign rx_s        = rx_sync[1];
    assign rx_bit_end  = (rx_tcnt == 6'(OVERSAMPLE - 1));
    assign rx_stop_end = (rx_state == ST_STOP) && tick && (rx_tcnt == 6'(STOP_TICKS - 1));
    // With longer stop periods the stop bit was sampled earlier and held in rx_stop_bad.
    assign rx_stop_low = rx_bit_end ? !rx_s : rx_stop_bad;
    assign frame_evt   = rx_stop_end && rx_stop_low;
    assign overrun_evt = rx_stop_end && r_full && !rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sync     <= 2'b11;
            rx_state    <= ST_IDLE;
            rx_tcnt     <= '0;
            rx_bits     <= '0;
            rx_shift    <= '0;
            rx_stop_bad <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], r_in};
            case (rx_state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= ST_START;
                        rx_tcnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_tcnt == 6'(START_MID - 1)) begin
                            rx_tcnt  <= '0;
                            rx_bits  <= '0;
                            rx_state <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            rx_tcnt <= rx_tcnt + 6'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (rx_bit_end) begin
                            rx_tcnt  <= '0;
                            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                            rx_bits  <= rx_bits + 4'd1;
                            if (rx_bits == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                                rx_state <= ST_PARITY;
`else
                                rx_state <= ST_STOP;
`endif
                            end
                        end else begin
                            rx_tcnt <= rx_tcnt + 6'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (rx_bit_end) begin
                            rx_tcnt  <= '0;
                            rx_state <= ST_STOP;
                        end else begin
                            rx_tcnt <= rx_tcnt + 6'd1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (rx_bit_end) rx_stop_bad <= !rx_s;
                        if (rx_stop_end) begin
                            rx_state <= ST_IDLE;
                            rx_tcnt  <= '0;
                        end else begin
                            rx_tcnt <= rx_tcnt + 6'd1;
                        end
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_W)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_stop_end),
        .pop       (rd),
        .w_data    (rx_shift),
        .r_data    (r_data),
        .next_data (rx_next_unused),
        .empty     (r_empty),
        .full      (r_full),
        .count     (rx_count_unused)
    );

    uart_state_t          tx_state;
    logic [5:0]           tx_tcnt;
    logic [3:0]           tx_bits;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit_end;
    logic                 tx_stop_end;
    logic                 tx_more;
    logic [DATA_BITS-1:0] tx_load;
    logic [DATA_BITS-1:0] t_head;
    logic [DATA_BITS-1:0] t_next;
    logic                 t_empty;
    logic [FIFO_W:0]      t_count;
    logic                 t_many;

    assign t_many      = (t_count > (FIFO_W+1)'(1));
    assign tx_bit_end  = (tx_tcnt == 6'(OVERSAMPLE - 1));
    assign tx_stop_end = (tx_state == ST_STOP) && tick && (tx_tcnt == 6'(STOP_TICKS - 1));
    // The current word is still in the FIFO at stop end, so a follower is the second entry or a same-cycle write.
    assign tx_more     = t_many || wr;
    assign tx_load     = (tx_state == ST_IDLE) ? t_head : (t_many ? t_next : w_data);
    assign tx_busy     = (tx_state != ST_IDLE);

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic tx_par;
`else
    logic parity_cfg_unused;
    assign parity_cfg_unused = (PARITY_ODD != 0);
`endif

    // Every transition waits for a tick so each bit lasts an exact number of ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_tcnt  <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            t_out    <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tick) begin
            case (tx_state)
                ST_IDLE: begin
                    if (!t_empty) begin
                        tx_shift <= tx_load;
                        tx_tcnt  <= '0;
                        tx_state <= ST_START;
                        t_out    <= 1'b0;
`ifdef UART_PARITY_EN
                        tx_par   <= parity_bit(9'(tx_load), PAR_ODD);
`endif
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_tcnt  <= '0;
                        tx_bits  <= '0;
                        tx_state <= ST_DATA;
                        t_out    <= tx_shift[0];
                    end else begin
                        tx_tcnt <= tx_tcnt + 6'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_tcnt <= '0;
                        if (tx_bits == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state <= ST_PARITY;
                            t_out    <= tx_par;
`else
                            tx_state <= ST_STOP;
                            t_out    <= 1'b1;
`endif
                        end else begin
                            tx_bits  <= tx_bits + 4'd1;
                            tx_shift <= tx_shift >> 1;
                            t_out    <= tx_shift[1];
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 6'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tx_bit_end) begin
                        tx_tcnt  <= '0;
                        tx_state <= ST_STOP;
                        t_out    <= 1'b1;
                    end else begin
                        tx_tcnt <= tx_tcnt + 6'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_tcnt == 6'(STOP_TICKS - 1)) begin
                        tx_tcnt <= '0;
                        if (tx_more) begin
                            tx_shift <= tx_load;
                            tx_state <= ST_START;
                            t_out    <= 1'b0;
`ifdef UART_PARITY_EN
                            tx_par   <= parity_bit(9'(tx_load), PAR_ODD);
`endif
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + 6'd1;
                    end
                end
                default: begin
                    tx_state <= ST_IDLE;
                    t_out    <= 1'b1;
                end
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_W)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr),
        .pop       (tx_stop_end),
        .w_data    (w_data),
        .r_data    (t_head),
        .next_data (t_next),
        .empty     (t_empty),
        .full      (t_full),
        .count     (t_count)
    );

    // A new event wins over a coincident clear so no error is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_frame   <= (err_frame && !err_clr) || frame_evt;
            err_overrun <= (err_overrun && !err_clr) || overrun_evt;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_evt;

    assign parity_evt = (rx_state == ST_PARITY) && tick && rx_bit_end &&
                        (rx_s != parity_bit(9'(rx_shift), PAR_ODD));

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_parity <= 1'b0;
        end else begin
            err_parity <= (err_parity && !err_clr) || parity_evt;
        end
    end
`else
    assign err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl at divisor 4 (one bit = 64 clocks).
// Frames carry a parity bit when UART_PARITY_EN is defined.
module tb_uart_ctrl;

    localparam int BIT_CYC = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] divisor;
    logic        rd, wr, err_clr;
    logic [7:0]  w_data;
    logic        r_in, t_out;
    logic [7:0]  r_data;
    logic        r_empty, r_full, t_full, tx_busy;
    logic        err_frame, err_parity, err_overrun;
    logic        loop_en;
    logic        r_drv;

    int n_checks = 0;
    int n_errors = 0;

    assign r_in = loop_en ? t_out : r_drv;

    always #5 clk = ~clk;

    uart_ctrl #(
        .DATA_BITS  (8),
        .STOP_TICKS (16),
        .FIFO_W     (2),
        .DIV_W      (16),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .divisor     (divisor),
        .rd          (rd),
        .wr          (wr),
        .w_data      (w_data),
        .r_in        (r_in),
        .t_out       (t_out),
        .r_data      (r_data),
        .r_empty     (r_empty),
        .r_full      (r_full),
        .t_full      (t_full),
        .tx_busy     (tx_busy),
        .err_frame   (err_frame),
        .err_parity  (err_parity),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int n);
        r_drv = b;
        skip(n);
    endtask

    task automatic apply_stimulus(input logic [7:0] d);
        w_data = d;
        wr     = 1'b1;
        @(negedge clk);
        wr     = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
`ifdef UART_PARITY_EN
        drive_bit(^d, BIT_CYC);
`endif
        if (stop_low > 0) drive_bit(1'b0, stop_low);
        drive_bit(1'b1, 2 * BIT_CYC - stop_low);
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check_output({tag, "_nonempty"}, 32'(r_empty), 32'd0);
        check_output(tag, 32'(r_data), 32'(exp));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        logic       found;
        logic [7:0] pattern;

        reset   = 1'b0;
        divisor = 16'd4;
        rd      = 1'b0;
        wr      = 1'b0;
        err_clr = 1'b0;
        w_data  = 8'h00;
        loop_en = 1'b0;
        r_drv   = 1'b1;
        skip(4);
        reset = 1'b1;
        skip(1);

        check_output("rst_t_out", 32'(t_out), 32'd1);
        check_output("rst_r_empty", 32'(r_empty), 32'd1);
        check_output("rst_r_full", 32'(r_full), 32'd0);
        check_output("rst_t_full", 32'(t_full), 32'd0);
        check_output("rst_tx_busy", 32'(tx_busy), 32'd0);
        check_output("rst_err_frame", 32'(err_frame), 32'd0);
        check_output("rst_err_parity", 32'(err_parity), 32'd0);
        check_output("rst_err_overrun", 32'(err_overrun), 32'd0);
        check_output("rst_r_data", 32'(r_data), 32'd0);

        $display("[TB] transmit 0xA5 bit timing");
        apply_stimulus(8'hA5);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (t_out === 1'b0) found = 1'b1;
        end
        check_output("tx_start_seen", 32'(found), 32'd1);
        check_output("tx_busy_start", 32'(tx_busy), 32'd1);
        skip(BIT_CYC - 1);
        check_output("tx_start_last", 32'(t_out), 32'd0);
        skip(1);
        check_output("tx_bit0_first", 32'(t_out), 32'd1);
        pattern = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            skip(BIT_CYC / 2);
            check_output($sformatf("tx_bit%0d", k), 32'(t_out), 32'(pattern[k]));
            skip(BIT_CYC / 2);
        end
`ifdef UART_PARITY_EN
        skip(BIT_CYC / 2);
        check_output("tx_parity", 32'(t_out), 32'd0);
        skip(BIT_CYC / 2);
`endif
        skip(BIT_CYC / 2);
        check_output("tx_stop", 32'(t_out), 32'd1);
        check_output("tx_busy_stop", 32'(tx_busy), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) found = 1'b1;
        end
        check_output("tx_idle_after", 32'(found), 32'd1);
        check_output("tx_idle_line", 32'(t_out), 32'd1);

        $display("[TB] loopback 00 FF 3C");
        loop_en = 1'b1;
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        apply_stimulus(8'h3C);
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) found = 1'b1;
        end
        check_output("loop_tx_done", 32'(found), 32'd1);
        skip(50);
        pop_rx("loop_w0", 8'h00);
        pop_rx("loop_w1", 8'hFF);
        pop_rx("loop_w2", 8'h3C);
        check_output("loop_drained", 32'(r_empty), 32'd1);
        check_output("loop_err_frame", 32'(err_frame), 32'd0);
        check_output("loop_err_parity", 32'(err_parity), 32'd0);
        check_output("loop_err_overrun", 32'(err_overrun), 32'd0);
        loop_en = 1'b0;

        $display("[TB] start-bit glitch");
        drive_bit(1'b0, 12);
        drive_bit(1'b1, 300);
        check_output("glitch_r_empty", 32'(r_empty), 32'd1);
        check_output("glitch_err_frame", 32'(err_frame), 32'd0);

        $display("[TB] framing error on 0x55");
        send_frame(8'h55, 40);
        skip(50);
        check_output("ferr_set", 32'(err_frame), 32'd1);
        check_output("ferr_no_overrun", 32'(err_overrun), 32'd0);
        pop_rx("ferr_word", 8'h55);
        check_output("ferr_single_push", 32'(r_empty), 32'd1);
        check_output("ferr_sticky", 32'(err_frame), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("ferr_cleared", 32'(err_frame), 32'd0);

        $display("[TB] overrun with five frames");
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        send_frame(8'h33, 0);
        send_frame(8'h44, 0);
        check_output("ovr_not_yet", 32'(err_overrun), 32'd0);
        send_frame(8'h55, 0);
        check_output("ovr_r_full", 32'(r_full), 32'd1);
        check_output("ovr_err", 32'(err_overrun), 32'd1);
        check_output("ovr_no_ferr", 32'(err_frame), 32'd0);
        pop_rx("ovr_w0", 8'h11);
        check_output("ovr_not_full", 32'(r_full), 32'd0);
        pop_rx("ovr_w1", 8'h22);
        pop_rx("ovr_w2", 8'h33);
        pop_rx("ovr_w3", 8'h44);
        check_output("ovr_drained", 32'(r_empty), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("ovr_cleared", 32'(err_overrun), 32'd0);

`ifdef UART_PARITY_EN
        $display("[TB] parity error on 0x07");
        drive_bit(1'b0, BIT_CYC);
        pattern = 8'h07;
        for (int i = 0; i < 8; i++) drive_bit(pattern[i], BIT_CYC);
        drive_bit(1'b0, BIT_CYC);
        drive_bit(1'b1, 2 * BIT_CYC);
        check_output("perr_set", 32'(err_parity), 32'd1);
        check_output("perr_no_ferr", 32'(err_frame), 32'd0);
        pop_rx("perr_word", 8'h07);
`else
        check_output("parity_tied_low", 32'(err_parity), 32'd0);
`endif

        $display("[TB] reset mid-frame");
        loop_en = 1'b1;
        apply_stimulus(8'h0F);
        skip(300);
        check_output("mid_busy", 32'(tx_busy), 32'd1);
        reset = 1'b0;
        skip(2);
        check_output("mid_rst_t_out", 32'(t_out), 32'd1);
        check_output("mid_rst_busy", 32'(tx_busy), 32'd0);
        check_output("mid_rst_r_empty", 32'(r_empty), 32'd1);
        reset = 1'b1;
        skip(800);
        check_output("mid_no_push", 32'(r_empty), 32'd1);
        check_output("mid_no_tx", 32'(tx_busy), 32'd0);
        check_output("mid_no_ferr", 32'(err_frame), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
